sisc_ctrl_mc: RTL and testbench

Parametrised multi-cycle control FSM for the SISC datapath, successor to the fixed 7-state controller. Adds conditional branch resolution from status flags, load/store sequencing with a memory request/acknowledge handshake and watchdog, two-cycle SWP writeback, and a sticky HALT state with an error flag. Sits between the instruction register decode fields and all datapath control points (PC, IR, register file, ALU, data memory).

---
 rtl/sisc_pkg.sv | 34 +++
 rtl/sisc_br_cond.sv | 42 ++++
 rtl/sisc_ctrl_mc.sv | 165 ++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC control definitions: opcodes, mode constants, ALU select codes, FSM states.
package sisc_pkg;

  localparam int OP_NOOP = 0;
  localparam int OP_LOD  = 1;
  localparam int OP_STR  = 2;
  localparam int OP_SWP  = 3;
  localparam int OP_BRA  = 4;
  localparam int OP_BRR  = 5;
  localparam int OP_BNE  = 6;
  localparam int OP_BNR  = 7;
  localparam int OP_ALU  = 8;
  localparam int OP_HLT  = 15;

  // Mode value selecting the immediate operand path.
  localparam int AM_IMM = 8;

  localparam logic [1:0] AOP_REG     = 2'b00;
  localparam logic [1:0] AOP_ADD_IMM = 2'b01;
  localparam logic [1:0] AOP_IDLE    = 2'b10;
  localparam logic [1:0] AOP_IMM_WB  = 2'b11;

  typedef enum logic [2:0] {
    START1  = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    WB2     = 3'd6,
    HALT    = 3'd7
  } state_t;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch resolution: taken/relative from opcode, condition mask and status flags.
// Purely combinational, no handshake.
module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int OPW = 4,
  parameter int MMW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [MMW-1:0] mm,
  input  logic [MMW-1:0] stat,
  output logic           taken,
  output logic           rel
);

  logic hit;

  // An all-zero mask never hits, so BRA/BRR fall through and BNE/BNR always go.
  assign hit = |(mm & stat);

  always_comb begin
    taken = 1'b0;
    rel   = 1'b0;
    case (opcode)
      OPW'(OP_BRA): taken = hit;
      OPW'(OP_BRR): begin
        taken = hit;
        rel   = 1'b1;
      end
      OPW'(OP_BNE): taken = !hit;
      OPW'(OP_BNR): begin
        taken = !hit;
        rel   = 1'b1;
      end
      default: begin
        taken = 1'b0;
        rel   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sisc_ctrl_mc.sv
// Multi-cycle SISC controller: 5-cycle instructions (SWP 6, LOD/STR 5 + ack wait).
// Memory requests hold until mem_ack; a watchdog halts with a sticky fault on timeout.
module sisc_ctrl_mc
  import sisc_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int MMW    = 4,
  parameter int ALUW   = 2,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [OPW-1:0]  opcode,
  input  logic [MMW-1:0]  mm,
  input  logic [MMW-1:0]  stat,
  input  logic            mem_ack,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            rb_sel,
  output logic            br_sel,
  output logic            pc_rst,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            ir_load,
  output logic [ALUW-1:0] alu_op,
  output logic            mem_req,
  output logic            dm_we,
  output logic            halted,
  output logic            fault
);

  localparam int CW = (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wd_cnt;
  logic [CW-1:0] wd_inc;
  logic          wd_hit;
  logic          wd_trip;
  logic          taken;
  logic          rel;
  logic          is_alu;
  logic          is_str;
  logic          is_mem;
  logic          imm;

  sisc_br_cond #(
    .OPW(OPW),
    .MMW(MMW)
  ) u_br_cond (
    .opcode(opcode),
    .mm    (mm),
    .stat  (stat),
    .taken (taken),
    .rel   (rel)
  );

  assign is_alu = opcode == OPW'(OP_ALU);
  assign is_str = opcode == OPW'(OP_STR);
  assign is_mem = (opcode == OPW'(OP_LOD)) || is_str;
  assign imm    = mm == MMW'(AM_IMM);

  // Expiry looks at the incremented count so a timeout halts on the edge it is reached.
  assign wd_inc = wd_cnt + CW'(1);
  assign wd_hit = (MEM_TO != 0) && (wd_inc == CW'(MEM_TO));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= START1;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    rb_sel     = 1'b0;
    br_sel     = 1'b0;
    pc_rst     = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    ir_load    = 1'b0;
    alu_op     = ALUW'(AOP_IDLE);
    mem_req    = 1'b0;
    dm_we      = 1'b0;
    wd_trip    = 1'b0;
    case (state)
      START1: begin
        pc_rst     = 1'b1;
        next_state = FETCH;
      end
      FETCH: begin
        ir_load    = 1'b1;
        pc_write   = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        if (taken) begin
          pc_sel   = 1'b1;
          pc_write = 1'b1;
          br_sel   = rel;
        end
        next_state = (opcode == OPW'(OP_HLT)) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        alu_op     = ((is_alu && imm) || is_mem) ? ALUW'(AOP_ADD_IMM) : ALUW'(AOP_REG);
        next_state = MEM;
      end
      MEM: begin
        next_state = WB;
        if (is_alu) begin
          alu_op = imm ? ALUW'(AOP_IMM_WB) : ALUW'(AOP_IDLE);
        end else if (is_mem) begin
          mem_req = 1'b1;
          dm_we   = is_str;
          // An ack sampled on the expiry edge still completes the access.
          if (!mem_ack) begin
            if (wd_hit) begin
              wd_trip    = 1'b1;
              next_state = HALT;
            end else begin
              next_state = MEM;
            end
          end
        end
      end
      WB: begin
        case (opcode)
          OPW'(OP_ALU): rf_we = 1'b1;
          OPW'(OP_LOD): begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
          end
          OPW'(OP_SWP): rf_we = 1'b1;
          default:      rf_we = 1'b0;
        endcase
        next_state = (opcode == OPW'(OP_SWP)) ? WB2 : FETCH;
      end
      WB2: begin
        rf_we      = 1'b1;
        rb_sel     = 1'b1;
        next_state = FETCH;
      end
      HALT: next_state = HALT;
      default: next_state = START1;
    endcase
  end

  // Outside MEM the count sits at zero, so every MEM visit starts fresh.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)              wd_cnt <= '0;
    else if (state != MEM)   wd_cnt <= '0;
    else if (!mem_ack)       wd_cnt <= wd_inc;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      if (next_state == HALT) halted <= 1'b1;
      if (wd_trip)            fault  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed bench for sisc_ctrl_mc: an instruction-timeline model queues the expected
// control vector for every cycle and a negedge process compares the DUT against it.
module tb_sisc_ctrl_mc;

  localparam int TO = 15;

  localparam int P_START = 0;
  localparam int P_FETCH = 1;
  localparam int P_DEC   = 2;
  localparam int P_EXE   = 3;
  localparam int P_MEM   = 4;
  localparam int P_WB    = 5;
  localparam int P_WB2   = 6;
  localparam int P_HALT  = 7;

  logic       clk = 1'b0;
  logic       rst_f = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [3:0] mm = 4'd0;
  logic [3:0] stat = 4'd0;
  logic       mem_ack = 1'b0;
  logic       rf_we, wb_sel, rb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
  logic [1:0] alu_op;
  logic       mem_req, dm_we, halted, fault;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  logic m_fault = 1'b0;
  int n;

  sisc_ctrl_mc #(
    .OPW(4), .MMW(4), .ALUW(2), .MEM_TO(TO)
  ) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_ack(mem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .rb_sel(rb_sel), .br_sel(br_sel), .pc_rst(pc_rst),
    .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load), .alu_op(alu_op),
    .mem_req(mem_req), .dm_we(dm_we), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  wire [13:0] got = {pc_rst, ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, rb_sel,
                     alu_op, mem_req, dm_we, halted, fault};

  // Expected controls for one cycle of an instruction's timeline.
  function automatic logic [13:0] vec(input int ph, input logic [3:0] op, input logic [3:0] m,
                                      input logic [3:0] s, input logic flt);
    logic [13:0] v;
    logic hit;
    v = 14'd0;
    v[5:4] = 2'b10;
    hit = (m & s) != 4'd0;
    case (ph)
      P_START: v[13] = 1'b1;
      P_FETCH: begin v[12] = 1'b1; v[11] = 1'b1; end
      P_DEC: begin
        if (((op == 4 || op == 5) && hit) || ((op == 6 || op == 7) && !hit)) begin
          v[11] = 1'b1;
          v[10] = 1'b1;
          v[9]  = (op == 5 || op == 7);
        end
      end
      P_EXE: v[5:4] = ((op == 8 && m == 8) || op == 1 || op == 2) ? 2'b01 : 2'b00;
      P_MEM: begin
        if (op == 8) v[5:4] = (m == 8) ? 2'b11 : 2'b10;
        if (op == 1 || op == 2) begin v[3] = 1'b1; v[2] = (op == 2); end
      end
      P_WB: begin
        if (op == 8 || op == 1 || op == 3) v[8] = 1'b1;
        if (op == 1) v[7] = 1'b1;
      end
      P_WB2: begin v[8] = 1'b1; v[6] = 1'b1; end
      P_HALT: begin v[1] = 1'b1; v[0] = flt; end
      default: v = 14'd0;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    logic [13:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ctl_vec t=%0t got=%b exp=%b", $time, got, e);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int ph, input logic [3:0] op, input logic [3:0] m,
                      input logic [3:0] s, input logic ack);
    @(posedge clk);
    #1;
    opcode = op; mm = m; stat = s; mem_ack = ack;
    exp_q.push_back(vec(ph, op, m, s, m_fault));
  endtask

  task automatic reset_seq();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rst_f = (i == 2);
      mem_ack = 1'b0;
      m_fault = 1'b0;
      exp_q.push_back(vec(P_START, 4'd0, 4'd0, 4'd0, 1'b0));
    end
  endtask

  // ack_wait: MEM cycle index where ack arrives (-1 never); rst_at: MEM index to reset at.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                           input int ack_wait, input int rst_at, input logic noise,
                           output int ncyc);
    ncyc = 0;
    step(P_FETCH, op, m, s, noise);
    step(P_DEC, op, m, s, noise);
    ncyc += 2;
    if (op == 15) begin
      repeat (3) begin step(P_HALT, op, m, s, 1'b1); ncyc++; end
      return;
    end
    step(P_EXE, op, m, s, noise);
    ncyc++;
    if (op == 1 || op == 2) begin
      for (int k = 0; k < 1000; k++) begin
        if (k == rst_at) begin reset_seq(); return; end
        step(P_MEM, op, m, s, k == ack_wait);
        ncyc++;
        if (k == ack_wait) break;
        if (k + 1 == TO) begin
          m_fault = 1'b1;
          repeat (3) begin step(P_HALT, op, m, s, 1'b1); ncyc++; end
          return;
        end
      end
    end else begin
      step(P_MEM, op, m, s, noise);
      ncyc++;
    end
    step(P_WB, op, m, s, noise);
    ncyc++;
    if (op == 3) begin step(P_WB2, op, m, s, noise); ncyc++; end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Hand-computed vectors pinning the model.
    check("model_start", int'(vec(P_START, 4'd0, 4'd0, 4'd0, 1'b0)), int'(14'b10000000100000));
    check("model_brr_dec", int'(vec(P_DEC, 4'd5, 4'd2, 4'd2, 1'b0)), int'(14'b00111000100000));
    check("model_str_mem", int'(vec(P_MEM, 4'd2, 4'd0, 4'd0, 1'b0)), int'(14'b00000000101100));
    check("model_lod_exe", int'(vec(P_EXE, 4'd1, 4'd0, 4'd0, 1'b0)), int'(14'b00000000010000));
    check("model_alu_imm_mem", int'(vec(P_MEM, 4'd8, 4'd8, 4'd0, 1'b0)), int'(14'b00000000110000));

    at_neg();
    check("rst_pc_rst", int'(pc_rst), 1);
    check("rst_alu_op", int'(alu_op), 2);
    reset_seq();

    run_instr(4'd8, 4'd0, 4'd0, -1, -1, 1'b1, n);
    check("alu_latency", n, 5);
    at_neg();
    check("alu_wb_rf_we", int'(rf_we), 1);
    run_instr(4'd8, 4'd8, 4'd0, -1, -1, 1'b0, n);
    run_instr(4'd5, 4'd2, 4'd2, -1, -1, 1'b0, n);
    run_instr(4'd5, 4'd2, 4'd4, -1, -1, 1'b0, n);
    run_instr(4'd6, 4'd0, 4'hf, -1, -1, 1'b0, n);
    run_instr(4'd7, 4'd4, 4'd4, -1, -1, 1'b0, n);
    run_instr(4'd4, 4'd3, 4'd1, -1, -1, 1'b0, n);
    run_instr(4'd2, 4'd0, 4'd0, 3, -1, 1'b0, n);
    check("str_latency", n, 8);
    run_instr(4'd1, 4'd0, 4'd0, 0, -1, 1'b1, n);
    check("lod_zero_wait", n, 5);
    run_instr(4'd2, 4'd0, 4'd0, TO - 1, -1, 1'b0, n);
    check("str_ack_wins", n, 19);
    check("ack_wins_no_halt", int'(halted), 0);
    run_instr(4'd3, 4'd0, 4'd0, -1, -1, 1'b0, n);
    check("swp_latency", n, 6);
    at_neg();
    check("swp_wb2_rb_sel", int'(rb_sel), 1);
    run_instr(4'd0, 4'd0, 4'd0, -1, -1, 1'b1, n);
    run_instr(4'd9, 4'd8, 4'hf, -1, -1, 1'b0, n);

    run_instr(4'd1, 4'd0, 4'd0, -1, -1, 1'b0, n);
    at_neg();
    check("timeout_halted", int'(halted), 1);
    check("timeout_fault", int'(fault), 1);
    reset_seq();
    at_neg();
    check("reset_clr_halted", int'(halted), 0);
    check("reset_clr_fault", int'(fault), 0);

    run_instr(4'd2, 4'd0, 4'd0, -1, 2, 1'b0, n);
    run_instr(4'd8, 4'd0, 4'd0, -1, -1, 1'b0, n);

    run_instr(4'd15, 4'd0, 4'd0, -1, -1, 1'b0, n);
    at_neg();
    check("hlt_halted", int'(halted), 1);
    check("hlt_no_fault", int'(fault), 0);
    reset_seq();

    at_neg();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout t=%0t exp=finish", $time);
    $fatal(1);
  end

endmodule
